// File: rtl/led_bin_expander_pkg.sv
// Shared visualizer constants and the LED expander FSM state encoding.
// LEDCountCalc uses the same frame geometry.
package led_bin_expander_pkg;

    localparam int LEDS    = 50;
    localparam int BIN_QTY = 12;
    localparam int CW      = $clog2(LEDS);
    localparam int BW      = $clog2(BIN_QTY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        PAD  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/led_bin_expander.sv
// Expands a frame of per-bin LED counts into a stream of exactly LEDS LEDs,
// one bin index per LED, padding with off LEDs when the counts fall short.
module led_bin_expander #(
    parameter int LEDS    = led_bin_expander_pkg::LEDS,
    parameter int BIN_QTY = led_bin_expander_pkg::BIN_QTY,
    parameter int CW      = $clog2(LEDS),
    parameter int BW      = $clog2(BIN_QTY)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BIN_QTY-1:0][CW-1:0]    LEDCount,
    input  logic                          data_v,
    output logic                          ready_o,
    output logic [BW-1:0]                 led_bin_o,
    output logic                          led_on_o,
    output logic                          led_v_o,
    input  logic                          led_ready_i,
    output logic                          led_last_o,
    output logic                          done_o,
    output led_bin_expander_pkg::state_t  state_o
);
    import led_bin_expander_pkg::*;

    localparam int             LCW      = $clog2(LEDS + 1);
    localparam logic [LCW-1:0] LAST_IDX = LCW'(LEDS - 1);
    localparam logic [BW-1:0]  LAST_BIN = BW'(BIN_QTY - 1);

    // Handshake: an LED transfers on a rising edge where led_v_o & led_ready_i;
    // once led_v_o rises it and the LED fields hold until that transfer.
    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q [BIN_QTY];
    logic [CW-1:0]  cnt_d [BIN_QTY];
    logic [BW-1:0]  bin_q, bin_d;
    logic [LCW-1:0] led_cnt_q, led_cnt_d;
    logic           led_hs;
    logic           ready_d, led_v_d, led_on_d, led_last_d, done_d;
    logic [BW-1:0]  led_bin_d;

    assign led_hs  = led_v_o & led_ready_i;
    assign state_o = state_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        led_cnt_d = led_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (data_v) begin
                    for (int i = 0; i < BIN_QTY; i++) cnt_d[i] = LEDCount[i];
                    bin_d     = '0;
                    led_cnt_d = '0;
                    state_d   = EMIT;
                end
            end
            EMIT: begin
                if (cnt_q[bin_q] != '0) begin
                    if (led_hs) begin
                        cnt_d[bin_q] = cnt_q[bin_q] - CW'(1);
                        led_cnt_d    = led_cnt_q + LCW'(1);
                        // Reaching LEDS drops whatever counts are still left.
                        if (led_cnt_q == LAST_IDX) state_d = DONE;
                    end
                end else if (bin_q == LAST_BIN) begin
                    state_d = PAD;
                end else begin
                    bin_d = bin_q + BW'(1);
                end
            end
            PAD: begin
                if (led_hs) begin
                    led_cnt_d = led_cnt_q + LCW'(1);
                    if (led_cnt_q == LAST_IDX) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        ready_d    = (state_d == IDLE);
        done_d     = (state_d == DONE);
        led_v_d    = 1'b0;
        led_on_d   = 1'b0;
        led_bin_d  = '0;
        if (state_d == EMIT && cnt_d[bin_d] != '0) begin
            led_v_d   = 1'b1;
            led_on_d  = 1'b1;
            led_bin_d = bin_d;
        end else if (state_d == PAD) begin
            led_v_d = 1'b1;
        end
        led_last_d = led_v_d && (led_cnt_d == LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            for (int i = 0; i < BIN_QTY; i++) cnt_q[i] <= '0;
            bin_q      <= '0;
            led_cnt_q  <= '0;
            ready_o    <= 1'b1;
            led_v_o    <= 1'b0;
            led_on_o   <= 1'b0;
            led_bin_o  <= '0;
            led_last_o <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bin_q      <= bin_d;
            led_cnt_q  <= led_cnt_d;
            ready_o    <= ready_d;
            led_v_o    <= led_v_d;
            led_on_o   <= led_on_d;
            led_bin_o  <= led_bin_d;
            led_last_o <= led_last_d;
            done_o     <= done_d;
        end
    end

endmodule

// File: tb/tb_led_bin_expander.sv
// Randomized scoreboard bench for led_bin_expander: a frame-level model
// queues the expected LED stream and a negedge monitor checks it.
module tb_led_bin_expander;
    import led_bin_expander_pkg::*;

    localparam int W       = BW + 2;
    localparam int TIMEOUT = 2000;

    typedef logic [BIN_QTY-1:0][CW-1:0] frame_t;

    logic                       clk;
    logic                       rst;
    frame_t                     LEDCount;
    logic                       data_v;
    logic                       ready_o;
    logic [BW-1:0]              led_bin_o;
    logic                       led_on_o;
    logic                       led_v_o;
    logic                       led_ready_i;
    logic                       led_last_o;
    logic                       done_o;
    state_t                     state_o;

    logic [W-1:0] exp_q[$];
    int           errors = 0;
    int           checks = 0;
    int           done_cnt = 0;
    int           hs_cnt = 0;
    bit           rand_rdy = 0;

    led_bin_expander dut (
        .clk         (clk),
        .rst         (rst),
        .LEDCount    (LEDCount),
        .data_v      (data_v),
        .ready_o     (ready_o),
        .led_bin_o   (led_bin_o),
        .led_on_o    (led_on_o),
        .led_v_o     (led_v_o),
        .led_ready_i (led_ready_i),
        .led_last_o  (led_last_o),
        .done_o      (done_o),
        .state_o     (state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] pk(input bit last, input bit on, input int bin);
        return {last, on, BW'(bin)};
    endfunction

    // Reference model: bins in order, each repeated by its count, cut at LEDS,
    // then off LEDs up to LEDS; the final LED carries the last flag.
    task automatic model_frame(input frame_t counts);
        int n;
        n = 0;
        for (int b = 0; b < BIN_QTY; b++)
            for (int k = 0; k < int'(counts[b]) && n < LEDS; k++) begin
                exp_q.push_back(pk(n == LEDS - 1, 1'b1, b));
                n++;
            end
        while (n < LEDS) begin
            exp_q.push_back(pk(n == LEDS - 1, 1'b0, 0));
            n++;
        end
    endtask

    // driver tasks
    task automatic send_frame(input frame_t counts);
        int t;
        t = 0;
        @(posedge clk); #1;
        while (!ready_o && t < TIMEOUT) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (!ready_o) begin
            errors++;
            $display("FAIL ready_wait: ready_o=%0b after %0d cycles, required 1", ready_o, t);
        end
        model_frame(counts);
        LEDCount = counts;
        data_v   = 1'b1;
        @(posedge clk); #1;
        data_v   = 1'b0;
        for (int b = 0; b < BIN_QTY; b++) LEDCount[b] = CW'($urandom_range(0, 40));
    endtask

    task automatic wait_done(input string name);
        int start;
        int t;
        start = done_cnt;
        t = 0;
        while (done_cnt == start && t < TIMEOUT) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (done_cnt == start) begin
            errors++;
            $display("FAIL %s_done: no done_o within %0d cycles, required one", name, TIMEOUT);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_leftover: %0d expected LEDs never emitted, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        logic [BW+4:0] got;
        got = {ready_o, led_v_o, led_on_o, led_last_o, done_o, led_bin_o};
        checks++;
        if (got != {1'b1, 4'b0000, {BW{1'b0}}}) begin
            errors++;
            $display("FAIL %s_outs: {rdy,v,on,last,done,bin}=%b, required %b", name, got,
                     {1'b1, 4'b0000, {BW{1'b0}}});
        end
        checks++;
        if (state_o != IDLE) begin
            errors++;
            $display("FAIL %s_state: state=%0d, required %0d", name, state_o, IDLE);
        end
    endtask

    function automatic frame_t rand_frame();
        frame_t f;
        for (int b = 0; b < BIN_QTY; b++)
            f[b] = ($urandom_range(0, 3) == 0) ? CW'(0) : CW'($urandom_range(0, 9));
        return f;
    endfunction

    // downstream ready driver
    initial begin
        led_ready_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            led_ready_i = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // scoreboard monitor
    initial begin : monitor
        logic [W-1:0] cur;
        logic [W-1:0] stall_val;
        logic [W-1:0] exp;
        bit           stall_prev;
        bit           last_prev;
        bit           done_prev;
        stall_prev = 0;
        last_prev  = 0;
        done_prev  = 0;
        stall_val  = '0;
        forever begin
            @(negedge clk);
            cur = {led_last_o, led_on_o, led_bin_o};
            if (!rst) begin
                stall_prev = 0;
                last_prev  = 0;
                done_prev  = 0;
                hs_cnt     = 0;
            end else begin
                if (stall_prev) begin
                    checks++;
                    if (!led_v_o || cur != stall_val) begin
                        errors++;
                        $display("FAIL stall_hold: v=%0b {last,on,bin}=%b, required v=1 %b",
                                 led_v_o, cur, stall_val);
                    end
                end
                if (done_o || last_prev) begin
                    checks++;
                    if (done_o != last_prev) begin
                        errors++;
                        $display("FAIL done_pulse: done_o=%0b, required %0b", done_o, last_prev);
                    end
                end
                if (done_prev) begin
                    checks++;
                    if (!ready_o) begin
                        errors++;
                        $display("FAIL ready_after_done: ready_o=%0b, required 1", ready_o);
                    end
                end
                if (led_v_o) begin
                    checks++;
                    if (ready_o) begin
                        errors++;
                        $display("FAIL busy_ready: ready_o=%0b while emitting, required 0", ready_o);
                    end
                end
                if (led_v_o && led_ready_i) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL led_extra: got %b with nothing expected", cur);
                    end else begin
                        exp = exp_q.pop_front();
                        if (cur != exp) begin
                            errors++;
                            $display("FAIL led_%0d: {last,on,bin}=%b, required %b", hs_cnt, cur, exp);
                        end
                    end
                    hs_cnt = led_last_o ? 0 : hs_cnt + 1;
                end
                stall_prev = led_v_o && !led_ready_i;
                stall_val  = cur;
                last_prev  = led_v_o && led_ready_i && led_last_o;
                done_prev  = done_o;
                if (done_o) done_cnt++;
            end
        end
    end

    // stimulus
    initial begin : stim
        frame_t f_mix;
        frame_t f_zero;
        frame_t f_over;
        frame_t f;
        int     t;
        rst      = 1'b0;
        data_v   = 1'b0;
        LEDCount = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;

        f_mix = '0;
        f_mix[0] = CW'(10); f_mix[5] = CW'(1); f_mix[6] = CW'(10); f_mix[8] = CW'(10);
        f_zero = '0;
        f_over = '0;
        f_over[3] = CW'(40); f_over[7] = CW'(40);

        send_frame(f_mix);  wait_done("mixed");
        send_frame(f_zero); wait_done("all_zero");
        send_frame(f_over); wait_done("overflow");

        rand_rdy = 1;
        send_frame(f_mix);  wait_done("mixed_stall");

        // data_v pulsed mid-frame with different counts must be ignored
        send_frame(f_over);
        repeat (6) @(posedge clk);
        #1;
        for (int b = 0; b < BIN_QTY; b++) LEDCount[b] = CW'($urandom_range(1, 20));
        data_v = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        data_v = 1'b0;
        wait_done("ignore_data_v");

        // reset at LED 20 aborts the frame
        rand_rdy = 0;
        send_frame(f_mix);
        t = 0;
        while (hs_cnt < 20 && t < TIMEOUT) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (hs_cnt < 20) begin
            errors++;
            $display("FAIL reach_led20: hs_cnt=%0d, required 20", hs_cnt);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("abort");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (led_v_o || done_o || !ready_o) begin
            errors++;
            $display("FAIL no_resume: v=%0b done=%0b ready=%0b, required 0 0 1", led_v_o, done_o, ready_o);
        end
        send_frame(f_mix); wait_done("after_reset");

        // randomized back-to-back frames
        rand_rdy = 1;
        for (int n = 0; n < 8; n++) begin
            f = rand_frame();
            send_frame(f);
            wait_done($sformatf("rand%0d", n));
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_bin_expander.md
LED_BIN_EXPANDER -- requirements
Module: led_bin_expander

Interface
REQ-001 Parameter LEDS, default 50, is the number of physical LEDs per frame.
REQ-002 Parameter BIN_QTY, default 12, is the number of note bins.
REQ-003 Parameter CW, default $clog2(LEDS), is the width of each per-bin LED count.
REQ-004 Parameter BW, default $clog2(BIN_QTY), is the width of a bin index.
REQ-005 clk  input  1  single clock, rising-edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 LEDCount  input  BIN_QTY x CW  per-bin LED counts, packed [BIN_QTY-1:0][CW-1:0].
REQ-008 data_v  input  1  LEDCount valid; sampled only when ready_o=1.
REQ-009 ready_o  output  1  block idle; a new frame is accepted.
REQ-010 led_bin_o  output  BW  bin index assigned to the current LED.
REQ-011 led_on_o  output  1  1 means the LED is lit with led_bin_o; 0 means a pad (off) LED, with led_bin_o=0.
REQ-012 led_v_o  output  1  led_bin_o, led_on_o and led_last_o are valid.
REQ-013 led_ready_i  input  1  downstream accepts the LED when led_v_o & led_ready_i.
REQ-014 led_last_o  output  1  asserted with the LED at index LEDS-1.
REQ-015 done_o  output  1  one-cycle pulse, the cycle after the last LED is accepted.

Function
REQ-016 The FSM SHALL have states IDLE, EMIT, PAD and DONE.
REQ-017 In IDLE with data_v=1, the block SHALL register all LEDCount entries, clear the bin pointer and LED counter, and enter EMIT on the next edge.
- LEDCount changes after capture have no effect.
REQ-018 In EMIT, if the current bin's remaining count is nonzero:
- led_v_o=1, led_on_o=1, led_bin_o = bin pointer.
- On each handshake, decrement the remaining count and increment the LED counter.
REQ-019 In EMIT, a bin with a remaining count of 0 SHALL cost exactly one cycle with led_v_o=0, then the bin pointer advances.
REQ-020 After bin BIN_QTY-1 is exhausted with LED counter < LEDS, the FSM SHALL enter PAD.
- PAD emits led_on_o=0 LEDs until the LED counter reaches LEDS.
REQ-021 Once the LED counter reaches LEDS in EMIT or PAD (overflow: sum of counts > LEDS), the remaining counts SHALL be discarded; exactly LEDS LEDs are emitted per frame.
REQ-022 led_last_o SHALL be high only while the LED counter equals LEDS-1 and led_v_o=1.
REQ-023 After the led_last_o handshake the FSM SHALL enter DONE, pulse done_o for one cycle, then return to IDLE.
REQ-024 ready_o SHALL equal (state==IDLE).
- data_v outside IDLE is ignored.
- The earliest back-to-back frame is accepted the cycle after done_o.
REQ-025 While led_v_o=1 and led_ready_i=0, led_bin_o, led_on_o and led_last_o SHALL hold stable, and led_v_o SHALL remain high.
REQ-026 The LED counter SHALL be $clog2(LEDS+1) bits wide and never wrap.
REQ-027 All outputs SHALL be registered; the first LED appears no later than 1 + (number of leading zero-count bins) cycles after capture.

Reset
REQ-028 While rst=0, state=IDLE; ready_o=1; led_v_o, led_on_o, led_last_o and done_o =0; led_bin_o=0; captured counts, bin pointer and LED counter =0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately with no done_o pulse; no partial frame resumes after release.

Structure
REQ-030 LEDS, BIN_QTY and the derived CW/BW widths, plus the FSM state enum, SHALL live in the shared visualizer package used by LEDCountCalc.
REQ-031 The block is a single module with no sub-modules; the count register bank is an in-module array.

Verification
REQ-032 LEDCount[0]=10, [5]=1, [6]=10, [8]=10, others 0, led_ready_i=1:
- 10x bin0, 1x bin5, 10x bin6, 10x bin8, all on.
- Then 19 pad LEDs.
- led_last_o on LED 49, done_o one cycle later.
REQ-033 All counts 0 -> 50 pad LEDs, led_on_o=0 throughout, led_last_o on the 50th.
REQ-034 LEDCount[3]=40, [7]=40 -> 40x bin3, then 10x bin7, no pad; done_o after LED 49.
REQ-035 Frame of REQ-032 with led_ready_i toggling pseudo-randomly -> same 50-LED sequence, outputs stable while stalled.
REQ-036 data_v pulsed during EMIT -> ignored; a reset pulse at LED 20 -> all outputs return to reset values, ready_o=1, and a following frame plays cleanly from LED 0.
